int_exec_pipe_v2: RTL
=====================

Name: int_exec_pipe_v2

Overview:
- Parametrised, handshaked successor to the single-stage integer vector execute unit.
- Executes one vector integer instruction per cycle across LANES lanes. Uses the existing FuncCode_t R-type, I-type and LLI/LUI opcode groups and the SYS_* ID reads.
- Fixed latency of PIPE_DEPTH cycles. Carries lane mask and destination-register tag alongside the data.
- Uses valid/ready backpressure with bubble collapse and a flush input. Sits between the reservation station (RSV) issue stage and writeback.

Parameters:
- LANES, 16, vector lanes (power of two, 1..32).
- DWIDTH, 32, lane word width.
- PIPE_DEPTH, 3, total stages from input to output register (2..6).
- RSV_CAPACITY, 4, reservation-station entries indexed by in_rid.
- REG_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  issue request
- in_ready  out  1  pipe accepts this cycle
- in_op  in  8  FuncCode_t
- in_a, in_b  in  LANES*DWIDTH  operand vectors
- in_imm  in  DWIDTH  immediate
- in_mask  in  LANES  active-lane mask
- in_dst  in  REG_BITS  destination register
- in_rid  in  $clog2(RSV_CAPACITY)  reservation entry
- block_id, block_dim, warp_id  in  RSV_CAPACITY*DWIDTH  per-entry IDs
- flush  in  1  kill all in-flight ops
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_data  out  LANES*DWIDTH  result vector
- out_mask  out  LANES  mask passthrough
- out_dst  out  REG_BITS  dst passthrough

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared. out_valid=0, out_data=0, out_mask=0, out_dst=0. in_ready is 1 from the first cycle after reset.
- Stage 0 latches inputs when in_valid and in_ready. Stage 1 computes the ALU result. Stages 2..PIPE_DEPTH-1 are register slices. Accepted-to-out_valid latency is exactly PIPE_DEPTH cycles when there is no backpressure.
- Advance rule:
  - stage k moves to k+1 when k+1 is empty or k+1 is itself moving.
  - The last stage empties when out_ready=1.
  - in_ready = !stage0_valid || stage0_moves. It is combinational from out_ready through the chain.
  - Bubbles collapse. Throughput is 1/cycle when out_ready is held high.
- A held stage keeps all its fields unchanged. out_* are stable while out_valid=1 and out_ready=0.
- ALU opcode groups:
  - op[7:5]=000: R-type OR, AND, XOR, ADD, SUB, MULT (low DWIDTH bits) and CMP* signed/unsigned. CMP results are 0/1 zero-extended.
  - op[7:5]=010: SHL/SHR/ASHR by imm[4:0]; CLZ/CTZ (CLZ/CTZ of 0 = DWIDTH); ADDI/SUBI/MULTI wrap modulo 2^DWIDTH; SYS_BLOCK_DIM, SYS_BLOCK_IDX; SYS_THREAD_IDX = warp_id[rid]*LANES + lane.
  - op[7:5]=101: LLI=imm, LUI=imm<<12.
- Any other op or group gives result 0. Result is never X.
- Masked lanes (mask bit 0) produce 0 in out_data. The mask is passed through unchanged.
- flush=1 clears every stage valid bit at the next edge. An in_valid presented in the same cycle is dropped; in_ready may be 1 but the op is discarded. out_valid=0 the cycle after flush.
- rst wins over flush. rst mid-stream discards all in-flight ops with no output.
- in_op, in_rid and the IDs are sampled only on acceptance. Later changes to block_id etc. do not affect in-flight ops.

Test Plan:
- Back-to-back ADD, out_ready=1, a=lane index, b=100, mask=all ones, 8 ops → 8 consecutive out_valid cycles starting exactly 3 cycles after the first accept; lane i = i+100.
- out_ready=0 for 5 cycles mid-stream → exactly PIPE_DEPTH ops accepted then in_ready=0. Held output unchanged. On release, no loss or duplication and original order is preserved.
- SUBI a=0, imm=1 → 0xFFFFFFFF. MULT a=0x10000, b=0x10000 → 0. ASHR a=0x80000000, imm=4 → 0xF8000000. CLZ of 0 → 32. CMPLT_I a=-1, b=1 → 1; CMPLT_U same operands → 0.
- SYS_THREAD_IDX, warp_id[2]=3, rid=2, mask=0x00FF → lanes 0..7 = 48..55, lanes 8..15 = 0, out_mask=0x00FF.
- Fill 3 ops, assert flush together with a new in_valid → out_valid stays 0 for the next 4 cycles. The next op accepted afterwards emerges after 3 cycles.
- rst asserted for 1 cycle with 2 ops in flight → all out_* = 0 the next cycle. Neither op ever appears.

Source files
------------

// File: rtl/int_exec_pipe_v2.sv
// int_exec_pipe_v2 : pipelined vector integer execute unit.
//
// Executes one vector integer instruction per cycle across LANES lanes.
// Stage 0 captures the issued instruction, stage 1 computes the ALU result,
// and stages 2..PIPE_DEPTH-1 are register slices. Valid/ready handshake with
// bubble collapse, plus a flush that kills everything in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         issue handshake from the reservation station
//   in_op                       FuncCode_t opcode (group in op[7:5])
//   in_a, in_b                  operand vectors, LANES x DWIDTH
//   in_imm                      immediate, shared by all lanes
//   in_mask                     active-lane mask (inactive lanes give 0)
//   in_dst                      destination register tag
//   in_rid                      reservation entry, selects the per-entry IDs
//   block_id, block_dim, warp_id  per-entry IDs, RSV_CAPACITY x DWIDTH
//   flush                       drop all in-flight ops at the next edge
//   out_valid / out_ready       result handshake towards writeback
//   out_data, out_mask, out_dst result vector, mask and tag
//
// Opcode map (op[7:5] group, op[4:0] function):
//   000 R-type : 0 OR, 1 AND, 2 XOR, 3 ADD, 4 SUB, 5 MULT, 6 CMPEQ, 7 CMPNE,
//                8 CMPLT_I, 9 CMPLT_U, 10 CMPLE_I, 11 CMPLE_U
//   010 I-type : 0 SHL, 1 SHR, 2 ASHR, 3 CLZ, 4 CTZ, 5 ADDI, 6 SUBI, 7 MULTI,
//                8 SYS_BLOCK_DIM, 9 SYS_BLOCK_IDX, 10 SYS_THREAD_IDX
//   101 U-type : 0 LLI, 1 LUI
//   anything else produces 0.
module int_exec_pipe_v2 #(
  parameter int LANES        = 16,
  parameter int DWIDTH       = 32,
  parameter int PIPE_DEPTH   = 3,
  parameter int RSV_CAPACITY = 4,
  parameter int REG_BITS     = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_op,
  input  logic [LANES*DWIDTH-1:0]          in_a,
  input  logic [LANES*DWIDTH-1:0]          in_b,
  input  logic [DWIDTH-1:0]                in_imm,
  input  logic [LANES-1:0]                 in_mask,
  input  logic [REG_BITS-1:0]              in_dst,
  input  logic [$clog2(RSV_CAPACITY)-1:0]  in_rid,
  input  logic [RSV_CAPACITY*DWIDTH-1:0]   block_id,
  input  logic [RSV_CAPACITY*DWIDTH-1:0]   block_dim,
  input  logic [RSV_CAPACITY*DWIDTH-1:0]   warp_id,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*DWIDTH-1:0]          out_data,
  output logic [LANES-1:0]                 out_mask,
  output logic [REG_BITS-1:0]              out_dst
);

  localparam int VW = LANES * DWIDTH;

  logic [PIPE_DEPTH-1:0] vld_p;
  logic [PIPE_DEPTH-1:0] move;
  logic                  free;
  logic                  accept;

  logic [7:0]            op_p0;
  logic [VW-1:0]         a_p0;
  logic [VW-1:0]         b_p0;
  logic [DWIDTH-1:0]     imm_p0;
  logic [DWIDTH-1:0]     bdim_p0;
  logic [DWIDTH-1:0]     bid_p0;
  logic [DWIDTH-1:0]     warp_p0;
  logic [LANES-1:0]      mask_p0;
  logic [REG_BITS-1:0]   dst_p0;

  logic [VW-1:0]         alu_res;

  logic [VW-1:0]         res_pn  [1:PIPE_DEPTH-1];
  logic [LANES-1:0]      mask_pn [1:PIPE_DEPTH-1];
  logic [REG_BITS-1:0]   dst_pn  [1:PIPE_DEPTH-1];

  function automatic logic [DWIDTH-1:0] flag(input logic f);
    return {{(DWIDTH-1){1'b0}}, f};
  endfunction

  function automatic logic [DWIDTH-1:0] clz(input logic [DWIDTH-1:0] v);
    int cnt;
    cnt = DWIDTH;
    // Walking upward, the last set bit seen is the most significant one.
    for (int i = 0; i < DWIDTH; i++)
      if (v[i]) cnt = DWIDTH - 1 - i;
    return DWIDTH'(cnt);
  endfunction

  function automatic logic [DWIDTH-1:0] ctz(input logic [DWIDTH-1:0] v);
    int cnt;
    cnt = DWIDTH;
    for (int i = DWIDTH - 1; i >= 0; i--)
      if (v[i]) cnt = i;
    return DWIDTH'(cnt);
  endfunction

  function automatic logic [DWIDTH-1:0] alu_lane(
    input logic [7:0]        op,
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b,
    input logic [DWIDTH-1:0] imm,
    input logic [DWIDTH-1:0] bdim,
    input logic [DWIDTH-1:0] bid,
    input logic [DWIDTH-1:0] warp,
    input int                lane
  );
    logic signed [DWIDTH-1:0] sa;
    logic signed [DWIDTH-1:0] sb;
    logic [DWIDTH-1:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op[7:5])
      3'b000: begin
        case (op[4:0])
          5'd0:    r = a | b;
          5'd1:    r = a & b;
          5'd2:    r = a ^ b;
          5'd3:    r = a + b;
          5'd4:    r = a - b;
          5'd5:    r = a * b;
          5'd6:    r = flag(a == b);
          5'd7:    r = flag(a != b);
          5'd8:    r = flag(sa < sb);
          5'd9:    r = flag(a < b);
          5'd10:   r = flag(sa <= sb);
          5'd11:   r = flag(a <= b);
          default: r = '0;
        endcase
      end
      3'b010: begin
        case (op[4:0])
          5'd0:    r = a << imm[4:0];
          5'd1:    r = a >> imm[4:0];
          5'd2:    r = $unsigned(sa >>> imm[4:0]);
          5'd3:    r = clz(a);
          5'd4:    r = ctz(a);
          5'd5:    r = a + imm;
          5'd6:    r = a - imm;
          5'd7:    r = a * imm;
          5'd8:    r = bdim;
          5'd9:    r = bid;
          5'd10:   r = warp * DWIDTH'(LANES) + DWIDTH'(lane);
          default: r = '0;
        endcase
      end
      3'b101: begin
        case (op[4:0])
          5'd0:    r = imm;
          5'd1:    r = imm << 12;
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // A stage can advance when some stage downstream of it is empty, or when the
  // whole chain below it is full and the consumer is taking the last one.
  // Scanning from the output end avoids a bitwise feedback on move.
  always_comb begin
    move = '0;
    free = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      move[k] = vld_p[k] & free;
      free    = free | ~vld_p[k];
    end
  end

  assign in_ready = ~vld_p[0] | move[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept | (vld_p[0] & ~move[0]);
      for (int k = 1; k < PIPE_DEPTH; k++)
        vld_p[k] <= move[k-1] | (vld_p[k] & ~move[k]);
    end
  end

  // ---- stage 0 : capture the issued instruction and its per-entry IDs ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= in_op;
      a_p0    <= in_a;
      b_p0    <= in_b;
      imm_p0  <= in_imm;
      mask_p0 <= in_mask;
      dst_p0  <= in_dst;
      bdim_p0 <= block_dim[int'(in_rid)*DWIDTH +: DWIDTH];
      bid_p0  <= block_id[int'(in_rid)*DWIDTH +: DWIDTH];
      warp_p0 <= warp_id[int'(in_rid)*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    alu_res = '0;
    for (int l = 0; l < LANES; l++) begin
      if (mask_p0[l])
        alu_res[l*DWIDTH +: DWIDTH] = alu_lane(op_p0,
                                               a_p0[l*DWIDTH +: DWIDTH],
                                               b_p0[l*DWIDTH +: DWIDTH],
                                               imm_p0, bdim_p0, bid_p0,
                                               warp_p0, l);
    end
  end

  // ---- stage 1 : ALU result; stages 2..PIPE_DEPTH-1 : register slices ----
  always_ff @(posedge clk) begin
    if (move[0]) begin
      res_pn[1]  <= alu_res;
      mask_pn[1] <= mask_p0;
      dst_pn[1]  <= dst_p0;
    end
    for (int k = 2; k < PIPE_DEPTH; k++) begin
      if (move[k-1]) begin
        res_pn[k]  <= res_pn[k-1];
        mask_pn[k] <= mask_pn[k-1];
        dst_pn[k]  <= dst_pn[k-1];
      end
    end
  end

  // ---- output : gated so that an empty pipe always presents zeros ----
  assign out_valid = vld_p[PIPE_DEPTH-1];
  assign out_data  = out_valid ? res_pn[PIPE_DEPTH-1]  : '0;
  assign out_mask  = out_valid ? mask_pn[PIPE_DEPTH-1] : '0;
  assign out_dst   = out_valid ? dst_pn[PIPE_DEPTH-1]  : '0;

endmodule
